// File: rtl/mem_requester_pkg.sv
`default_nettype none
// ============================================================================
// mem_requester_pkg
// Shared state encoding and default geometry for the dataMem requester.
// Revision: 1.0
// ============================================================================
package mem_requester_pkg;

    localparam int unsigned        DEF_ADDR_W     = 4;
    localparam int unsigned        DEF_DATA_W     = 16;
    localparam logic [15:0]        DEF_INIT_VALUE = 16'h0000;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_WR   = 3'd2,
        ST_RD   = 3'd3,
        ST_CAPT = 3'd4,
        ST_RESP = 3'd5
    } state_t;

endpackage : mem_requester_pkg
`default_nettype wire

// File: rtl/mem_requester.sv
`default_nettype none
// ============================================================================
// mem_requester
// Turns pipeline load/store requests into registered dataMem cycles and
// returns load data; clears the memory to INIT_VALUE after reset.
// Revision: 1.0
// ============================================================================
module mem_requester
    import mem_requester_pkg::*;
#(
    parameter int unsigned       ADDR_W         = DEF_ADDR_W,
    parameter int unsigned       DATA_W         = DEF_DATA_W,
    parameter logic [DATA_W-1:0] INIT_VALUE     = DATA_W'(DEF_INIT_VALUE),
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_wrAddr,
    output logic [ADDR_W-1:0] mem_rdAddr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam state_t            c_RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt;
    logic                r_init_done;
    logic                w_init_done;
    logic                r_rsp_valid;
    logic                w_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [DATA_W-1:0]   w_rsp_rdata;
    logic                r_mem_write;
    logic                w_mem_write;
    logic                r_mem_read;
    logic                w_mem_read;
    logic [ADDR_W-1:0]   r_mem_wr_addr;
    logic [ADDR_W-1:0]   w_mem_wr_addr;
    logic [ADDR_W-1:0]   r_mem_rd_addr;
    logic [ADDR_W-1:0]   w_mem_rd_addr;
    logic [DATA_W-1:0]   r_mem_data_in;
    logic [DATA_W-1:0]   w_mem_data_in;
    logic                w_accept;

    // init_done gating keeps req_ready low while reset is asserted even when
    // the sweep is disabled and the reset state is IDLE.
    assign req_ready = (r_state == ST_IDLE) && r_init_done;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_next        = r_state;
        w_cnt         = r_cnt;
        w_init_done   = r_init_done;
        w_rsp_valid   = 1'b0;
        w_rsp_rdata   = r_rsp_rdata;
        w_mem_write   = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_wr_addr = '0;
        w_mem_rd_addr = '0;
        w_mem_data_in = '0;

        case (r_state)
            ST_INIT: begin
                // Leave only once the last sweep write has been presented.
                if (r_mem_write && (r_mem_wr_addr == c_LAST_ADDR)) begin
                    w_next      = ST_IDLE;
                    w_init_done = 1'b1;
                end else begin
                    w_mem_write   = 1'b1;
                    w_mem_wr_addr = r_cnt;
                    w_mem_data_in = INIT_VALUE;
                    w_cnt         = r_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                w_init_done = 1'b1;
                if (w_accept) begin
                    if (req_we) begin
                        w_next        = ST_WR;
                        w_mem_write   = 1'b1;
                        w_mem_wr_addr = req_addr;
                        w_mem_data_in = req_wdata;
                    end else begin
                        w_next        = ST_RD;
                        w_mem_read    = 1'b1;
                        w_mem_rd_addr = req_addr;
                    end
                end
            end
            ST_WR: begin
                w_next = ST_IDLE;
            end
            ST_RD: begin
                w_next = ST_CAPT;
            end
            ST_CAPT: begin
                w_rsp_rdata = mem_data_out;
                w_rsp_valid = 1'b1;
                w_next      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_rsp_valid = 1'b1;
                end
            end
            default: begin
                w_next = c_RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_RST_STATE;
            r_cnt         <= '0;
            r_init_done   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_rd_addr <= '0;
            r_mem_data_in <= '0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= w_cnt;
            r_init_done   <= w_init_done;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_mem_write   <= w_mem_write;
            r_mem_read    <= w_mem_read;
            r_mem_wr_addr <= w_mem_wr_addr;
            r_mem_rd_addr <= w_mem_rd_addr;
            r_mem_data_in <= w_mem_data_in;
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign init_done   = r_init_done;
    assign mem_write   = r_mem_write;
    assign mem_read    = r_mem_read;
    assign mem_wrAddr  = r_mem_wr_addr;
    assign mem_rdAddr  = r_mem_rd_addr;
    assign mem_data_in = r_mem_data_in;

endmodule : mem_requester
`default_nettype wire
